sorted_bundle_serializer: RTL and testbench
===========================================

Name: sorted_bundle_serializer

Overview:
- Drains the 4-word sorted bundle produced by the pipelined 4-input sorter and emits it one word per cycle on a valid/ready stream.
- Word order is ascending or descending, selected per bundle.
- Checks each accepted bundle for sortedness and flags violations.
- Sits between the sorter output and any word-serial consumer; a 2-entry bundle buffer lets back-to-back bundles stream with no bubble.

Parameters:
DW, 8, width of one data word (unsigned)
CW, 16, width of the completed-bundle counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  bundle offered
in_ready  output  1  bundle can be accepted
in_data  input  DW*4  lane0 = [DW-1:0] (smallest) … lane3 = [DW*4-1:DW*3] (largest)
in_desc  input  1  sampled with bundle: 0 = emit lane0..3, 1 = emit lane3..0
out_valid  output  1  word valid
out_ready  input  1  consumer accepts word
out_data  output  DW  current word
out_idx  output  2  emission position within bundle, 0..3
out_last  output  1  high when out_idx == 3
order_err  output  1  sticky: an accepted bundle was not non-decreasing
err_clr  input  1  clears order_err
bundle_cnt  output  CW  count of fully emitted bundles, wraps

Behaviour:
- Reset (rst high at an edge) forces out_valid=0, out_idx=0, out_last=0, order_err=0, bundle_cnt=0, both buffer entries empty. in_ready is 0 while rst is high and 1 in the first cycle after.
- Storage:
  - ACTIVE entry: bundle being drained, with its in_desc.
  - PENDING entry: next bundle.
  - in_ready = !rst && !pending_full.
- Handshakes:
  - Input transfer = in_valid && in_ready at an edge.
  - Output transfer = out_valid && out_ready at an edge.
- Output-side states:
  - IDLE: active empty, out_valid=0.
  - DRAIN: active full, out_valid=1.
- IDLE + input transfer at edge k: bundle loads into active, word counter = 0, state DRAIN. First word is visible in cycle k+1, so latency is 1 cycle.
- DRAIN, output transfer with counter < 3: counter increments.
- DRAIN, output transfer with counter == 3 (bundle done): bundle_cnt increments (wraps 2^CW-1 -> 0), then one of:
  - pending full: pending moves to active, pending empties, counter = 0, stay DRAIN (zero bubble).
  - pending empty and input transfer in the same edge: new bundle loads directly into active, counter = 0, stay DRAIN.
  - otherwise: go to IDLE.
- DRAIN + input transfer and active not finishing: bundle loads into pending.
- Word selection: out_data = active lane[counter] when desc=0, lane[3-counter] when desc=1. out_idx = counter.
- Output stability: out_data, out_idx, out_last and out_valid hold while out_valid && !out_ready.
- Arithmetic:
  - Ordering check is unsigned: lane0<=lane1<=lane2<=lane3. Equal values are legal.
  - Evaluated on input transfer. A violation sets order_err at that edge.
  - The bundle is still emitted unmodified.
- order_err: err_clr clears it. If a set and err_clr occur at the same edge, the set wins.
- Simultaneous events:
  - An input transfer plus the finish of the active bundle with pending full cannot happen, because in_ready=0.
  - Input and output transfers at the same edge are both honoured.
- Reset mid-bundle: all buffered data is discarded. The partial bundle is not counted and no further words of it are emitted.
- No combinational path from out_ready to in_ready. in_ready depends only on registered pending_full and rst.

Test Plan:
1. Single ascending bundle: in_data lanes {0x03,0x07,0x07,0xF0}, in_desc=0, out_ready=1 → out_data 03,07,07,F0 on 4 consecutive cycles starting 1 cycle after accept; out_last on F0; bundle_cnt=1; order_err=0.
2. Descending with backpressure: lanes {01,02,03,04}, in_desc=1, out_ready low for 3 cycles during word 1 → sequence 04,03,02,01; word 03 with out_idx=1 held stable for the whole stall.
3. Back-to-back: three bundles offered continuously, out_ready=1 → 12 consecutive valid words with no gap. in_ready drops to 0 while both entries are full. bundle_cnt=3.
4. Order violation: lanes {05,02,09,0A} → order_err=1 the cycle after accept; words 05,02,09,0A still emitted. err_clr asserted in the same cycle as another bad bundle is accepted → order_err stays 1.
5. Reset mid-drain: rst asserted after word 1 of a bundle → next cycle out_valid=0, bundle_cnt=0, pending empty; the following bundle {10,20,30,40} emits cleanly.
6. Counter wrap (CW=4 override): 17 bundles → bundle_cnt reads 1.

Source files
------------

// File: rtl/sorted_bundle_serializer.sv
// Serializes 4-word sorted bundles into a word stream (ascending or descending per bundle).
// A pending slot behind the active bundle allows bubble-free back-to-back bundles.
module sorted_bundle_serializer #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW*4-1:0] in_data,
    input  logic          in_desc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_idx,
    output logic          out_last,
    output logic          order_err,
    input  logic          err_clr,
    output logic [CW-1:0] bundle_cnt
);

    typedef enum logic {StIdle, StDrain} state_e;

    state_e            state_q, state_d;
    logic [DW*4-1:0]   act_data_q, act_data_d;
    logic [DW*4-1:0]   pend_data_q, pend_data_d;
    logic              act_desc_q, act_desc_d;
    logic              pend_desc_q, pend_desc_d;
    logic              pend_full_q, pend_full_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              order_err_q, order_err_d;
    logic [CW-1:0]     bundle_cnt_q, bundle_cnt_d;

    logic              in_xfer, out_xfer, finish, in_sorted;
    logic [1:0]        lane_sel;

    // in_ready depends only on registered state and rst, never on out_ready.
    assign in_ready   = !rst && !pend_full_q;
    assign out_valid  = (state_q == StDrain);
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    assign finish     = out_xfer && (cnt_q == 2'd3);
    assign in_sorted  = (in_data[0*DW +: DW] <= in_data[1*DW +: DW]) &&
                        (in_data[1*DW +: DW] <= in_data[2*DW +: DW]) &&
                        (in_data[2*DW +: DW] <= in_data[3*DW +: DW]);

    assign lane_sel   = act_desc_q ? (2'd3 - cnt_q) : cnt_q;
    assign out_idx    = cnt_q;
    assign out_last   = (cnt_q == 2'd3);
    assign order_err  = order_err_q;
    assign bundle_cnt = bundle_cnt_q;

    always_comb begin
        out_data = '0;
        unique case (lane_sel)
            2'd0:    out_data = act_data_q[0*DW +: DW];
            2'd1:    out_data = act_data_q[1*DW +: DW];
            2'd2:    out_data = act_data_q[2*DW +: DW];
            default: out_data = act_data_q[3*DW +: DW];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        act_data_d   = act_data_q;
        act_desc_d   = act_desc_q;
        pend_data_d  = pend_data_q;
        pend_desc_d  = pend_desc_q;
        pend_full_d  = pend_full_q;
        cnt_d        = cnt_q;
        bundle_cnt_d = bundle_cnt_q;

        // A new violation outranks a simultaneous clear.
        order_err_d = err_clr ? 1'b0 : order_err_q;
        if (in_xfer && !in_sorted) begin
            order_err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (in_xfer) begin
                    act_data_d = in_data;
                    act_desc_d = in_desc;
                    cnt_d      = 2'd0;
                    state_d    = StDrain;
                end
            end
            StDrain: begin
                if (out_xfer && !finish) begin
                    cnt_d = cnt_q + 2'd1;
                end
                if (finish) begin
                    bundle_cnt_d = bundle_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    cnt_d        = 2'd0;
                    if (pend_full_q) begin
                        act_data_d  = pend_data_q;
                        act_desc_d  = pend_desc_q;
                        pend_full_d = 1'b0;
                    end else if (in_xfer) begin
                        act_data_d = in_data;
                        act_desc_d = in_desc;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (in_xfer) begin
                    pend_data_d = in_data;
                    pend_desc_d = in_desc;
                    pend_full_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            act_data_q   <= '0;
            act_desc_q   <= 1'b0;
            pend_data_q  <= '0;
            pend_desc_q  <= 1'b0;
            pend_full_q  <= 1'b0;
            cnt_q        <= 2'd0;
            order_err_q  <= 1'b0;
            bundle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            act_data_q   <= act_data_d;
            act_desc_q   <= act_desc_d;
            pend_data_q  <= pend_data_d;
            pend_desc_q  <= pend_desc_d;
            pend_full_q  <= pend_full_d;
            cnt_q        <= cnt_d;
            order_err_q  <= order_err_d;
            bundle_cnt_q <= bundle_cnt_d;
        end
    end

endmodule

// File: tb/tb_sorted_bundle_serializer.sv
// Scoreboard bench: a word queue models buffered bundles; a negedge monitor checks every output.
module tb_sorted_bundle_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_desc = 1'b0;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] in_data = '0;

    logic        in_ready, out_valid, out_last, order_err;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic [15:0] bundle_cnt;
    logic        in_ready4, out_valid4, out_last4, order_err4;
    logic [7:0]  out_data4;
    logic [1:0]  out_idx4;
    logic [3:0]  bundle_cnt4;

    sorted_bundle_serializer #(.DW(8), .CW(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_desc(in_desc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .order_err(order_err), .err_clr(err_clr),
        .bundle_cnt(bundle_cnt)
    );

    // Narrow-counter instance for the wrap check; fed the same stimulus.
    sorted_bundle_serializer #(.DW(8), .CW(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .in_desc(in_desc), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_idx(out_idx4), .out_last(out_last4), .order_err(order_err4), .err_clr(err_clr),
        .bundle_cnt(bundle_cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] w;
        logic [1:0] idx;
    } word_t;

    word_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    m_cnt = 0;
    logic  m_err = 1'b0;
    bit    rand_ready = 0;
    bit    rand_clr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bundles are just sequences of 4 words in a FIFO; occupancy in bundles
    // tells whether a second slot is taken.
    always @(negedge clk) begin
        int         held;
        bit         exp_in_ready, ix, ox, viol;
        logic [7:0] l [4];
        word_t      e;
        held         = (exp_q.size() + 3) / 4;
        exp_in_ready = !rst && (held < 2);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_in_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0].w});
            chk("out_idx", {30'd0, out_idx}, {30'd0, exp_q[0].idx});
            chk("out_last", {31'd0, out_last}, {31'd0, exp_q[0].idx == 2'd3});
        end
        chk("order_err", {31'd0, order_err}, {31'd0, m_err});
        chk("bundle_cnt", {16'd0, bundle_cnt}, m_cnt % 65536);
        chk("bundle_cnt_cw4", {28'd0, bundle_cnt4}, m_cnt % 16);
        chk("out_data_cw4", {24'd0, out_data4}, {24'd0, out_data});

        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            ix = in_valid && exp_in_ready;
            ox = out_ready && (exp_q.size() != 0);
            viol = 0;
            if (ox) begin
                if (exp_q[0].idx == 2'd3) m_cnt++;
                void'(exp_q.pop_front());
            end
            if (ix) begin
                for (int i = 0; i < 4; i++) l[i] = in_data[i*8 +: 8];
                viol = !(l[0] <= l[1] && l[1] <= l[2] && l[2] <= l[3]);
                for (int k = 0; k < 4; k++) begin
                    e.w   = in_desc ? l[3-k] : l[k];
                    e.idx = k[1:0];
                    exp_q.push_back(e);
                end
            end
            m_err = viol ? 1'b1 : (err_clr ? 1'b0 : m_err);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(3) != 0);
        if (rand_clr) err_clr = ($urandom_range(15) == 0);
    end

    // Leaves in_valid high on return so consecutive calls offer bundles without a gap.
    task automatic send(input logic [31:0] d, input logic desc);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_desc  = desc;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=accept t=%0t", $time);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || out_valid) && n < 1000);
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            failures++;
            $display("FAIL drain_timeout actual=busy required=idle t=%0t", $time);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] sorted_rand();
        logic [7:0] b [4];
        logic [7:0] t;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (b[j] > b[j+1]) begin
                    t = b[j]; b[j] = b[j+1]; b[j+1] = t;
                end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: single ascending bundle
        out_ready = 1'b1;
        send(32'hF0070703, 1'b0);
        in_valid = 1'b0;
        drain();
        chk("t1_cnt", {16'd0, bundle_cnt}, 32'd1);

        // 2: descending with a 3-cycle stall on word 1
        out_ready = 1'b0;
        send(32'h04030201, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drain();

        // 3: three back-to-back bundles, no bubble
        out_ready = 1'b1;
        send(32'h44332211, 1'b0);
        send(32'h88776655, 1'b1);
        send(32'hCCBBAA99, 1'b0);
        drain();
        chk("t3_cnt", {16'd0, bundle_cnt}, 32'd5);

        // 4: order violation; then set and clear on the same edge
        send(32'h0A090205, 1'b0);
        in_valid = 1'b0;
        drain();
        chk("t4_err_set", {31'd0, order_err}, 32'd1);
        err_clr = 1'b1;
        send(32'h01020304, 1'b1);
        in_valid = 1'b0;
        err_clr  = 1'b0;
        drain();
        chk("t4_err_held", {31'd0, order_err}, 32'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("t4_err_clr", {31'd0, order_err}, 32'd0);
        @(posedge clk);
        #1;

        // 5: reset mid-drain with pending full
        out_ready = 1'b0;
        send(32'h0D0C0B0A, 1'b0);
        send(32'h1D1C1B1A, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_cnt", {16'd0, bundle_cnt}, 32'd0);
        @(posedge clk);
        #1;
        send(32'h40302010, 1'b0);
        in_valid = 1'b0;
        drain();

        // 6: counter wrap on the narrow instance
        do_reset();
        for (int i = 0; i < 17; i++) send(sorted_rand(), 1'($urandom));
        drain();
        chk("t6_wrap_cw4", {28'd0, bundle_cnt4}, 32'd1);
        chk("t6_cnt_cw16", {16'd0, bundle_cnt}, 32'd17);

        // Randomized traffic: backpressure, gaps, clears, occasional unsorted input
        rand_ready = 1;
        rand_clr   = 1;
        for (int i = 0; i < 60; i++) begin
            send(($urandom_range(1) != 0) ? sorted_rand() : $urandom, 1'($urandom));
            if ($urandom_range(2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(2)) @(posedge clk);
                #1;
            end
        end
        rand_ready = 0;
        rand_clr   = 0;
        @(posedge clk);
        #2;
        err_clr = 1'b0;
        drain();
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
